// File: rtl/apb_pkg.sv
// Shared APB definitions for the register-file completer.
package apb_pkg;

   localparam int APB_AW   = 32;
   localparam int APB_DW   = 32;
   localparam int NUM_PSEL = 3;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } apb_state_t;

endpackage

// File: rtl/apb_regfile.sv
// DEPTH x 32 register storage: one synchronous write port, one combinational read port.
module apb_regfile
   import apb_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int IW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [IW-1:0]     waddr,
   input  logic [APB_DW-1:0] wdata,
   input  logic [IW-1:0]     raddr,
   output logic [APB_DW-1:0] rdata
);

   logic [DEPTH-1:0][APB_DW-1:0] mem;

   // Storage: cleared on reset, single word written per cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer serving a word-addressed register file with programmable wait states.
module apb_slave_regfile
   import apb_pkg::*;
#(
   parameter int               SEL_BIT     = 0,
   parameter int               DEPTH       = 16,
   parameter int               WAIT_CYCLES = 0,
   parameter logic [APB_AW-1:0] BASE_ADDR  = 32'h0
) (
   input  logic                Hclk,
   input  logic                Hresetn,
   input  logic [NUM_PSEL-1:0] Pselx,
   input  logic                Penable,
   input  logic                Pwrite,
   input  logic [APB_AW-1:0]   Paddr,
   input  logic [APB_DW-1:0]   Pwdata,
   output logic [APB_DW-1:0]   Prdata,
   output logic                Pready,
   output logic                Pslverr
);

   localparam int               IW   = $clog2(DEPTH);
   localparam logic [APB_AW-1:0] SPAN = APB_AW'(4 * DEPTH);

   apb_state_t        state, state_d;
   logic [3:0]        cnt, cnt_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic              wr_q, wr_d;
   logic              err_q, err_d;
   logic [APB_DW-1:0] prdata_d;
   logic              we;
   logic [APB_DW-1:0] rdata;

   // Address decode; unsigned subtraction makes addresses below the base wrap out of range.
   logic              sel;
   logic [APB_AW-1:0] off;
   logic [IW-1:0]     dec_idx;
   logic              dec_err;

   assign sel     = Pselx[SEL_BIT];
   assign off     = Paddr - BASE_ADDR;
   assign dec_idx = off[2 +: IW];
   assign dec_err = (off[1:0] != 2'b00) || (off >= SPAN);

   apb_regfile #(.DEPTH(DEPTH), .IW(IW)) u_regfile (
      .clk   (Hclk),
      .rst_n (Hresetn),
      .we    (we),
      .waddr (idx_q),
      .wdata (Pwdata),
      .raddr (dec_idx),
      .rdata (rdata)
   );

   // State, wait counter, latched decode and registered read data.
   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         idx_q  <= '0;
         wr_q   <= 1'b0;
         err_q  <= 1'b0;
         Prdata <= '0;
      end else begin
         state  <= state_d;
         cnt    <= cnt_d;
         idx_q  <= idx_d;
         wr_q   <= wr_d;
         err_q  <= err_d;
         Prdata <= prdata_d;
      end
   end

   // Next state: capture on setup, count down waits, commit or abort in access.
   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      idx_d    = idx_q;
      wr_d     = wr_q;
      err_d    = err_q;
      prdata_d = Prdata;
      we       = 1'b0;
      case (state)
         ST_IDLE: begin
            // An access phase without a preceding setup phase is ignored.
            if (sel && !Penable) begin
               idx_d    = dec_idx;
               wr_d     = Pwrite;
               err_d    = dec_err;
               cnt_d    = 4'(WAIT_CYCLES);
               prdata_d = (!Pwrite && !dec_err) ? rdata : '0;
               state_d  = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (!(sel && Penable)) begin
               // Requester dropped the transfer: leave without writing, Prdata holds.
               state_d = ST_IDLE;
            end else if (cnt != 4'd0) begin
               cnt_d = cnt - 4'd1;
            end else begin
               we      = wr_q && !err_q;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign Pready  = (state == ST_ACCESS) && (cnt == 4'd0);
   assign Pslverr = Pready && err_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench: two completers on one bus (SEL_BIT 0 zero-wait, SEL_BIT 1 three waits).
module tb_apb_slave_regfile;

   logic        Hclk;
   logic        Hresetn;
   logic [2:0]  Pselx;
   logic        Penable;
   logic        Pwrite;
   logic [31:0] Paddr;
   logic [31:0] Pwdata;
   logic [31:0] Prdata0, Prdata1;
   logic        Pready0, Pready1;
   logic        Pslverr0, Pslverr1;

   int n_chk  = 0;
   int n_fail = 0;

   apb_slave_regfile #(.SEL_BIT(0), .DEPTH(16), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut0 (
      .Hclk(Hclk), .Hresetn(Hresetn), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
      .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(Prdata0), .Pready(Pready0), .Pslverr(Pslverr0)
   );

   apb_slave_regfile #(.SEL_BIT(1), .DEPTH(16), .WAIT_CYCLES(3), .BASE_ADDR(32'h0)) dut1 (
      .Hclk(Hclk), .Hresetn(Hresetn), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
      .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(Prdata1), .Pready(Pready1), .Pslverr(Pslverr1)
   );

   initial Hclk = 1'b0;
   always #5 Hclk = ~Hclk;

   task automatic idle();
      Pselx   = 3'b000;
      Penable = 1'b0;
      @(posedge Hclk); #1;
   endtask

   // Full transfer to completer s; reports wait cycles, error flag and Prdata at completion.
   task automatic xfer(input int s, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       output int waits, output logic err, output logic [31:0] rd);
      logic rdy;
      bit   done;
      Pselx   = 3'b001 << s;
      Penable = 1'b0;
      Pwrite  = wr;
      Paddr   = addr;
      Pwdata  = wd;
      @(posedge Hclk); #1;
      Penable = 1'b1;
      waits   = 0;
      err     = 1'b0;
      done    = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         rdy = (s == 0) ? Pready0 : Pready1;
         if (rdy) begin
            err  = (s == 0) ? Pslverr0 : Pslverr1;
            done = 1'b1;
         end else begin
            waits++;
         end
         @(posedge Hclk); #1;
      end
      rd = (s == 0) ? Prdata0 : Prdata1;
      if (!done) begin
         n_chk++; n_fail++;
         $display("FAIL xfer_timeout: sel=%0d addr=%h no Pready within 40 cycles", s, addr);
      end
   endtask

   task automatic test_reset();
      Hresetn = 1'b0;
      Pselx = 3'b000; Penable = 1'b0; Pwrite = 1'b0; Paddr = '0; Pwdata = '0;
      repeat (2) @(posedge Hclk);
      #1;
      n_chk++; if (Prdata0 !== 32'h0) begin n_fail++; $display("FAIL reset_prdata0: got %h want 0", Prdata0); end
      n_chk++; if (Pready0 !== 1'b0) begin n_fail++; $display("FAIL reset_pready0: got %b want 0", Pready0); end
      n_chk++; if (Pslverr0 !== 1'b0) begin n_fail++; $display("FAIL reset_pslverr0: got %b want 0", Pslverr0); end
      n_chk++; if (Prdata1 !== 32'h0) begin n_fail++; $display("FAIL reset_prdata1: got %h want 0", Prdata1); end
      n_chk++; if (Pready1 !== 1'b0) begin n_fail++; $display("FAIL reset_pready1: got %b want 0", Pready1); end
      Hresetn = 1'b1;
      idle();
   endtask

   task automatic test_zero_wait();
      int w; logic e; logic [31:0] rd;
      xfer(0, 1'b1, 32'h08, 32'hDEADBEEF, w, e, rd);
      n_chk++; if (w !== 0) begin n_fail++; $display("FAIL zw_write_waits: got %0d want 0", w); end
      n_chk++; if (e !== 1'b0) begin n_fail++; $display("FAIL zw_write_err: got %b want 0", e); end
      idle();
      xfer(0, 1'b0, 32'h08, 32'h0, w, e, rd);
      n_chk++; if (w !== 0) begin n_fail++; $display("FAIL zw_read_waits: got %0d want 0", w); end
      n_chk++; if (e !== 1'b0) begin n_fail++; $display("FAIL zw_read_err: got %b want 0", e); end
      n_chk++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL zw_read_data: got %h want deadbeef", rd); end
      idle(); idle();
      n_chk++; if (Prdata0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL zw_prdata_hold: got %h want deadbeef", Prdata0); end
      n_chk++; if (Pready0 !== 1'b0) begin n_fail++; $display("FAIL zw_pready_idle: got %b want 0", Pready0); end
   endtask

   task automatic test_wait_states();
      int w; logic e; logic [31:0] rd;
      xfer(1, 1'b0, 32'h04, 32'h0, w, e, rd);
      n_chk++; if (w !== 3) begin n_fail++; $display("FAIL ws_read_waits: got %0d want 3", w); end
      n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL ws_read_data: got %h want 0", rd); end
      idle();
      xfer(1, 1'b1, 32'h04, 32'h12345678, w, e, rd);
      n_chk++; if (w !== 3) begin n_fail++; $display("FAIL ws_write_waits: got %0d want 3", w); end
      idle();
      xfer(1, 1'b0, 32'h04, 32'h0, w, e, rd);
      n_chk++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL ws_readback: got %h want 12345678", rd); end
      idle();
   endtask

   task automatic test_errors();
      int w; logic e; logic [31:0] rd;
      xfer(0, 1'b1, 32'h42, 32'hFFFFFFFF, w, e, rd);
      n_chk++; if (e !== 1'b1) begin n_fail++; $display("FAIL err_misaligned: got %b want 1", e); end
      idle();
      xfer(0, 1'b0, 32'h08, 32'h0, w, e, rd);   // loads Prdata with nonzero data first
      xfer(0, 1'b0, 32'h40, 32'h0, w, e, rd);
      n_chk++; if (e !== 1'b1) begin n_fail++; $display("FAIL err_out_of_range: got %b want 1", e); end
      n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL err_rdata_zero: got %h want 0", rd); end
      idle();
      n_chk++; if (Pslverr0 !== 1'b0) begin n_fail++; $display("FAIL err_pslverr_idle: got %b want 0", Pslverr0); end
      xfer(0, 1'b0, 32'h00, 32'h0, w, e, rd);   // misaligned 0x42 decodes to idx 0
      n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL err_no_write: got %h want 0", rd); end
      idle();
   endtask

   task automatic test_back_to_back();
      int w; logic e; logic [31:0] rd;
      xfer(0, 1'b1, 32'h0C, 32'hCAFEF00D, w, e, rd);
      xfer(0, 1'b0, 32'h0C, 32'h0, w, e, rd);
      n_chk++; if (w !== 0) begin n_fail++; $display("FAIL b2b_waits: got %0d want 0", w); end
      n_chk++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL b2b_data: got %h want cafef00d", rd); end
      idle();
   endtask

   task automatic test_other_sel();
      int w; logic e; logic [31:0] rd;
      int bad;
      bad = 0;
      // Transfer addressed to bit 2: neither completer may respond.
      Pselx = 3'b100; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h08; Pwdata = 32'h11111111;
      @(posedge Hclk); #1;
      Penable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (Pready0 !== 1'b0 || Pready1 !== 1'b0) bad++;
         @(posedge Hclk); #1;
      end
      n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL other_sel_pready: %0d cycles with Pready high, want 0", bad); end
      idle();
      // Access phase on our bit with no setup phase.
      bad = 0;
      Pselx = 3'b001; Penable = 1'b1; Pwrite = 1'b1; Paddr = 32'h08; Pwdata = 32'h22222222;
      for (int i = 0; i < 3; i++) begin
         @(posedge Hclk); #1;
         if (Pready0 !== 1'b0) bad++;
      end
      n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL no_setup_pready: %0d cycles with Pready high, want 0", bad); end
      idle();
      xfer(0, 1'b0, 32'h08, 32'h0, w, e, rd);
      n_chk++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL other_sel_regs: got %h want deadbeef", rd); end
      idle();
   endtask

   task automatic test_abort();
      int w; logic e; logic [31:0] rd;
      Pselx = 3'b010; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h08; Pwdata = 32'hAAAA5555;
      @(posedge Hclk); #1;
      Penable = 1'b1;
      @(posedge Hclk); #1;
      idle();
      n_chk++; if (Pready1 !== 1'b0) begin n_fail++; $display("FAIL abort_pready: got %b want 0", Pready1); end
      xfer(1, 1'b0, 32'h08, 32'h0, w, e, rd);
      n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL abort_no_write: got %h want 0", rd); end
      idle();
   endtask

   task automatic test_reset_mid();
      int w; logic e; logic [31:0] rd;
      Pselx = 3'b010; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h0C; Pwdata = 32'h55555555;
      @(posedge Hclk); #1;          // cnt = 3
      Penable = 1'b1;
      @(posedge Hclk); #1;          // cnt = 2
      Hresetn = 1'b0;
      #1;
      n_chk++; if (Pready1 !== 1'b0 || Pslverr1 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_outputs: Pready=%b Pslverr=%b want 0 0", Pready1, Pslverr1); end
      n_chk++; if (Prdata1 !== 32'h0) begin n_fail++; $display("FAIL rst_mid_prdata: got %h want 0", Prdata1); end
      Pselx = 3'b000; Penable = 1'b0;
      repeat (2) @(posedge Hclk);
      #1;
      Hresetn = 1'b1;
      idle();
      xfer(1, 1'b0, 32'h0C, 32'h0, w, e, rd);
      n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rst_mid_no_commit: got %h want 0", rd); end
      n_chk++; if (w !== 3) begin n_fail++; $display("FAIL rst_after_waits: got %0d want 3", w); end
      xfer(1, 1'b0, 32'h04, 32'h0, w, e, rd);
      n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rst_clears_regs: got %h want 0", rd); end
      idle();
      xfer(0, 1'b1, 32'h10, 32'h0BADF00D, w, e, rd);
      xfer(0, 1'b0, 32'h10, 32'h0, w, e, rd);
      n_chk++; if (rd !== 32'h0BADF00D) begin n_fail++; $display("FAIL rst_after_xfer: got %h want 0badf00d", rd); end
      idle();
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_errors();
      test_back_to_back();
      test_other_sel();
      test_abort();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
